contador_bcd_n: RTL and testbench

//  Parametrised synchronous BCD up/down counter; next generation of the single-digit counter.
//  - N cascaded decimal digits.
//  - Full parallel load instead of fixed presets.
//  - Count enable; wrap or saturate mode.
//  - Terminal-count outputs for cascading further counters.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 51 +++++
 rtl/contador_bcd_n.sv | 103 ++++++++++
 tb/tb_contador_bcd_n.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD digit constants and the digit validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int              BCD_DIGIT_W = 4;
    localparam logic [3:0]      BCD_MAX     = 4'd9;
    localparam logic [3:0]      BCD_MIN     = 4'd0;

    function automatic logic is_bcd(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module      : bcd_digit
// Description : One decimal digit register with load, up/down count and
//               direction-dependent terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import bcd_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_DIGIT_W-1:0]  ld,
    input  logic                    en,
    input  logic                    i,
    output logic [BCD_DIGIT_W-1:0]  q,
    output logic                    tc
);

    logic [BCD_DIGIT_W-1:0] digit_q;
    logic [BCD_DIGIT_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = ld;
        end else if (en) begin
            if (i) begin
                digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q  = digit_q;
    assign tc = i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

`default_nettype wire

// File: rtl/contador_bcd_n.sv
// ============================================================================
// Module      : contador_bcd_n
// Description : N-digit synchronous BCD up/down counter with validated
//               parallel load, wrap/saturate modes and cascade flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_bcd_n
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SATURATE = 0
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    i,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_value,
    output logic [4*DIGITS-1:0]     S,
    output logic                    carry,
    output logic                    borrow,
    output logic                    at_max,
    output logic                    at_zero,
    output logic                    load_err
);

    localparam logic c_sat = (SATURATE != 0);

    logic               w_ld_valid;
    logic               w_load_accept;
    logic               w_sat_block;
    logic               w_count;
    logic [DIGITS-1:0]  w_tc;
    logic [DIGITS-1:0]  w_en;
    logic               load_err_q;
    logic               load_err_d;

    always_comb begin
        w_ld_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(load_value[4*k +: 4])) begin
                w_ld_valid = 1'b0;
            end
        end
    end

    always_comb begin
        at_max = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (S[4*k +: 4] != BCD_MAX) begin
                at_max = 1'b0;
            end
        end
    end

    assign at_zero       = (S == '0);
    assign w_load_accept = load & w_ld_valid;
    assign load_err_d    = load & ~w_ld_valid;

    // Any load request, accepted or not, suppresses counting in that cycle.
    assign w_sat_block   = c_sat & (i ? at_max : at_zero);
    assign w_count       = enable & ~load & ~w_sat_block;

    assign carry  = enable &  i & at_max  & ~load & ~c_sat;
    assign borrow = enable & ~i & at_zero & ~load & ~c_sat;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_first
                assign w_en[k] = w_count;
            end else begin : g_chain
                assign w_en[k] = w_en[k-1] & w_tc[k-1];
            end

            bcd_digit u_digit (
                .clock (clock),
                .reset (reset),
                .load  (w_load_accept),
                .ld    (load_value[4*k +: 4]),
                .en    (w_en[k]),
                .i     (i),
                .q     (S[4*k +: 4]),
                .tc    (w_tc[k])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_bcd_n.sv
// Testbench for contador_bcd_n: 2-digit wrap, 2-digit saturate and 3-digit
// wrap instances driven in parallel against an integer reference model.
`default_nettype none

module tb_contador_bcd_n;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, dir = 1'b0, ld = 1'b0;
    logic [11:0] lv = '0;

    logic [7:0]  s2, s2s;
    logic [11:0] s3;
    logic        c2, b2, am2, az2, le2;
    logic        c2s, b2s, am2s, az2s, le2s;
    logic        c3, b3, am3, az3, le3;
    logic [3:0]  f2, f2s, f3;

    assign f2  = {c2,  b2,  am2,  az2};
    assign f2s = {c2s, b2s, am2s, az2s};
    assign f3  = {c3,  b3,  am3,  az3};

    int n_vec = 0;
    int n_err = 0;

    int m2 = 0, m2s = 0, m3 = 0;
    bit e2 = 0, e2s = 0, e3 = 0;

    always #5 clk = ~clk;

    contador_bcd_n #(.DIGITS(2), .SATURATE(0)) dut (
        .clock(clk), .reset(rst), .enable(en), .i(dir), .load(ld),
        .load_value(lv[7:0]), .S(s2), .carry(c2), .borrow(b2),
        .at_max(am2), .at_zero(az2), .load_err(le2));

    contador_bcd_n #(.DIGITS(2), .SATURATE(1)) dut_sat (
        .clock(clk), .reset(rst), .enable(en), .i(dir), .load(ld),
        .load_value(lv[7:0]), .S(s2s), .carry(c2s), .borrow(b2s),
        .at_max(am2s), .at_zero(az2s), .load_err(le2s));

    contador_bcd_n #(.DIGITS(3), .SATURATE(0)) dut3 (
        .clock(clk), .reset(rst), .enable(en), .i(dir), .load(ld),
        .load_value(lv), .S(s3), .carry(c3), .borrow(b3),
        .at_max(am3), .at_zero(az3), .load_err(le3));

    // ---------------- reference model (decimal integers) ----------------
    function automatic int pow10(input int d);
        int r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

    // Returns -1 when any of the d nibbles is not a decimal digit.
    function automatic int bcd2int(input logic [31:0] b, input int d);
        int r = 0;
        logic [31:0] t = b;
        for (int k = d - 1; k >= 0; k--) begin
            int nib = int'((t >> (4 * k)) & 32'hF);
            if (nib > 9) return -1;
            r = r * 10 + nib;
        end
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input int v, input int d);
        logic [31:0] r = '0;
        int t = v;
        for (int k = 0; k < d; k++) begin
            r = r | (32'(t % 10) << (4 * k));
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int nextv(input int v, input int d, input bit sat);
        int mx = pow10(d) - 1;
        int lvi = bcd2int(32'(lv), d);
        if (rst) return 0;
        if (ld) return (lvi >= 0) ? lvi : v;
        if (!en) return v;
        if (dir) return (v == mx) ? (sat ? mx : 0) : v + 1;
        return (v == 0) ? (sat ? 0 : mx) : v - 1;
    endfunction

    function automatic bit nexterr(input int d);
        return !rst && ld && (bcd2int(32'(lv), d) < 0);
    endfunction

    function automatic logic [3:0] xflags(input int v, input int d, input bit sat);
        int mx = pow10(d) - 1;
        logic cy = en && dir && (v == mx) && !ld && !sat;
        logic bw = en && !dir && (v == 0) && !ld && !sat;
        return {cy, bw, logic'(v == mx), logic'(v == 0)};
    endfunction

    task automatic step();
        int n2, n2s, n3;
        @(posedge clk);
        n2  = nextv(m2, 2, 1'b0);
        n2s = nextv(m2s, 2, 1'b1);
        n3  = nextv(m3, 3, 1'b0);
        e2  = nexterr(2);
        e2s = nexterr(2);
        e3  = nexterr(3);
        m2 = n2; m2s = n2s; m3 = n3;
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic d,
                          input logic l, input logic [11:0] v);
        rst = r; en = e; dir = d; ld = l; lv = v;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_in(1, 1, 1, 1, 12'h123);
        step();
        set_in(0, 0, 0, 0, 12'h000);
        #1;
        n_vec++;
        if (s2 !== 8'h00 || le2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_s2: S=%h load_err=%b, expected S=00 load_err=0", s2, le2);
        end
        n_vec++;
        if (f2 !== 4'b0001 || f3 !== 4'b0001 || s3 !== 12'h000) begin
            n_err++;
            $display("FAIL reset_flags: f2=%b f3=%b s3=%h, expected 0001 0001 000", f2, f3, s3);
        end
    endtask

    task automatic test_count_up();
        set_in(1, 0, 0, 0, 12'h000);
        step();
        set_in(0, 1, 1, 0, 12'h000);
        for (int n = 0; n < 100; n++) begin
            #1;
            n_vec++;
            if (f2 !== xflags(m2, 2, 1'b0) || c2 !== (n == 99)) begin
                n_err++;
                $display("FAIL up_flags[%0d]: flags=%b, expected %b", n, f2, xflags(m2, 2, 1'b0));
            end
            step();
            n_vec++;
            if (32'(s2) !== int2bcd((n + 1) % 100, 2)) begin
                n_err++;
                $display("FAIL up_value[%0d]: S=%h, expected %0d", n, s2, (n + 1) % 100);
            end
        end
    endtask

    task automatic test_count_down();
        int exp_seq [7] = '{4, 3, 2, 1, 0, 99, 98};
        set_in(0, 0, 0, 1, 12'h005);
        step();
        set_in(0, 1, 0, 0, 12'h000);
        for (int n = 0; n < 7; n++) begin
            #1;
            n_vec++;
            if (b2 !== (m2 == 0) || f2 !== xflags(m2, 2, 1'b0)) begin
                n_err++;
                $display("FAIL down_flags[%0d]: flags=%b, expected %b", n, f2, xflags(m2, 2, 1'b0));
            end
            step();
            n_vec++;
            if (32'(s2) !== int2bcd(exp_seq[n], 2)) begin
                n_err++;
                $display("FAIL down_value[%0d]: S=%h, expected %0d", n, s2, exp_seq[n]);
            end
        end
    endtask

    task automatic test_saturate();
        set_in(0, 0, 0, 1, 12'h098);
        step();
        set_in(0, 1, 1, 0, 12'h000);
        for (int n = 0; n < 3; n++) begin
            #1;
            n_vec++;
            if (c2s !== 1'b0) begin
                n_err++;
                $display("FAIL sat_carry[%0d]: carry=%b, expected 0", n, c2s);
            end
            step();
            n_vec++;
            if (s2s !== 8'h99) begin
                n_err++;
                $display("FAIL sat_up[%0d]: S=%h, expected 99", n, s2s);
            end
        end
        set_in(0, 0, 0, 1, 12'h001);
        step();
        set_in(0, 1, 0, 0, 12'h000);
        for (int n = 0; n < 3; n++) begin
            #1;
            n_vec++;
            if (b2s !== 1'b0) begin
                n_err++;
                $display("FAIL sat_borrow[%0d]: borrow=%b, expected 0", n, b2s);
            end
            step();
            n_vec++;
            if (s2s !== 8'h00) begin
                n_err++;
                $display("FAIL sat_down[%0d]: S=%h, expected 00", n, s2s);
            end
        end
    endtask

    task automatic test_load_err();
        set_in(0, 0, 0, 1, 12'h042);
        step();
        set_in(0, 1, 1, 1, 12'h04A);
        step();
        n_vec++;
        if (s2 !== 8'h42 || le2 !== 1'b1 || s3 !== 12'h042 || le3 !== 1'b1) begin
            n_err++;
            $display("FAIL load_reject: S=%h err=%b s3=%h err3=%b, expected 42 1 042 1", s2, le2, s3, le3);
        end
        set_in(0, 1, 1, 1, 12'h037);
        step();
        n_vec++;
        if (s2 !== 8'h37 || le2 !== 1'b0) begin
            n_err++;
            $display("FAIL load_accept: S=%h err=%b, expected 37 0", s2, le2);
        end
        set_in(0, 0, 0, 1, 12'h0F0);
        step();
        set_in(0, 0, 0, 0, 12'h000);
        step();
        n_vec++;
        if (s2 !== 8'h37 || le2 !== 1'b0) begin
            n_err++;
            $display("FAIL load_err_pulse: S=%h err=%b, expected 37 0", s2, le2);
        end
    endtask

    task automatic test_reset_priority();
        set_in(0, 0, 0, 1, 12'h057);
        step();
        set_in(1, 1, 1, 1, 12'h011);
        step();
        n_vec++;
        if (s2 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_wins: S=%h, expected 00", s2);
        end
        set_in(0, 1, 1, 0, 12'h000);
        step(); step(); step();
        rst = 1'b1;
        step();
        n_vec++;
        if (s2 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: S=%h, expected 00", s2);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (s2 !== 8'h01) begin
            n_err++;
            $display("FAIL reset_resume: S=%h, expected 01", s2);
        end
    endtask

    task automatic test_enable_off();
        logic [7:0] held;
        set_in(0, 0, 0, 1, 12'h063);
        step();
        ld = 1'b0;
        held = 8'h63;
        for (int n = 0; n < 5; n++) begin
            dir = ~dir;
            step();
            n_vec++;
            if (s2 !== held) begin
                n_err++;
                $display("FAIL enable_off[%0d]: S=%h, expected %h", n, s2, held);
            end
        end
    endtask

    task automatic test_digits3();
        set_in(0, 0, 0, 1, 12'h099);
        step();
        set_in(0, 1, 1, 0, 12'h000);
        step();
        n_vec++;
        if (s3 !== 12'h100) begin
            n_err++;
            $display("FAIL d3_ripple: S=%h, expected 100", s3);
        end
        set_in(0, 0, 0, 1, 12'h999);
        step();
        set_in(0, 1, 1, 0, 12'h000);
        #1;
        n_vec++;
        if (c3 !== 1'b1 || am3 !== 1'b1) begin
            n_err++;
            $display("FAIL d3_carry: carry=%b at_max=%b, expected 1 1", c3, am3);
        end
        step();
        n_vec++;
        if (s3 !== 12'h000 || az3 !== 1'b1) begin
            n_err++;
            $display("FAIL d3_wrap: S=%h at_zero=%b, expected 000 1", s3, az3);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [11:0] v = '0;
            for (int k = 0; k < 3; k++) begin
                int nib = int'($urandom_range(0, 10));
                if (nib == 10) nib = int'($urandom_range(10, 15));
                v = v | (12'(nib) << (4 * k));
            end
            set_in(($urandom % 25) == 0, ($urandom % 4) != 0, $urandom % 2,
                   ($urandom % 6) == 0, v);
            #1;
            n_vec++;
            if (f2 !== xflags(m2, 2, 1'b0) || f2s !== xflags(m2s, 2, 1'b1) ||
                f3 !== xflags(m3, 3, 1'b0)) begin
                n_err++;
                $display("FAIL rnd_flags[%0d]: %b %b %b, expected %b %b %b", n, f2, f2s, f3,
                         xflags(m2, 2, 1'b0), xflags(m2s, 2, 1'b1), xflags(m3, 3, 1'b0));
            end
            step();
            n_vec++;
            if (32'(s2) !== int2bcd(m2, 2) || 32'(s2s) !== int2bcd(m2s, 2) ||
                32'(s3) !== int2bcd(m3, 3)) begin
                n_err++;
                $display("FAIL rnd_value[%0d]: %h %h %h, expected %0d %0d %0d",
                         n, s2, s2s, s3, m2, m2s, m3);
            end
            n_vec++;
            if (le2 !== e2 || le2s !== e2s || le3 !== e3) begin
                n_err++;
                $display("FAIL rnd_load_err[%0d]: %b %b %b, expected %b %b %b",
                         n, le2, le2s, le3, e2, e2s, e3);
            end
            n_vec++;
            if (bcd2int(32'(s3), 3) < 0 || bcd2int(32'(s2), 2) < 0 || bcd2int(32'(s2s), 2) < 0) begin
                n_err++;
                $display("FAIL rnd_non_bcd[%0d]: %h %h %h, expected all digits <= 9", n, s2, s2s, s3);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_err();
        test_reset_priority();
        test_enable_off();
        test_digits3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
